// File: rtl/register_pipeline.sv
// -----------------------------------------------------------------------------
// register_pipeline
//   Elastic pipeline register for the Maxnet datapath. STAGES back-to-back
//   WIDTH-bit register slices with a valid/ready handshake. An empty slice always
//   accepts, even when the slices after it are stalled. This collapses bubbles,
//   so a stalled pipe fills completely before it pushes back upstream. A
//   synchronous flush clears every slice. A registered occupancy count reports
//   how many slices hold valid data.
//
// Parameters
//   WIDTH        data bits per slice
//   STAGES       number of slices (>=1), equal to the unstalled latency in cycles
//   RESET_VALUE  value loaded into every data register on reset and on flush
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous reset, active low (0 = reset)
//   flush      in   synchronous clear of all slices, active high
//   in_valid   in   upstream word valid
//   in_ready   out  slice 0 can accept this cycle (combinational from out_ready)
//   in_data    in   upstream word
//   out_valid  out  last slice holds a valid word (registered)
//   out_ready  in   downstream accepts this cycle
//   out_data   out  last-slice data register
//   occupancy  out  number of valid slices, 0..STAGES (registered)
// -----------------------------------------------------------------------------
module register_pipeline #(
    parameter int               WIDTH       = 32,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] stage_valid;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic [STAGES-1:0] stage_ready;
    logic [STAGES-1:0] src_valid;
    logic [WIDTH-1:0]  src_data   [STAGES];
    logic              push;
    logic              pop;

    // The recursive rule ready[i] = !v[i] | ready[i+1] unrolls to
    // "out_ready, or any empty slice at or after i". Computing it in this flat
    // form keeps the ready vector free of a combinational self-dependency.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        stage_ready = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_ready[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!stage_valid[j]) begin
                    stage_ready[i] = 1'b1;
                end
            end
        end
    end

    // Slice 0 is fed from the upstream port. Every later slice is fed from the slice before it.
    always_comb begin
        src_valid    = '0;
        src_data     = '{default: '0};
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = stage_valid[i-1];
            src_data[i]  = stage_data[i-1];
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[STAGES-1];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Reset and flush take the same action. Flush drops a word arriving in the
    // same cycle. A word leaving in the same cycle has already been taken by
    // downstream, so clearing the last slice completes that transfer.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            stage_valid <= '0;
            // NOTE: the data registers are cleared as well, not only the valids, so out_data reads RESET_VALUE after reset or flush.
            for (int i = 0; i < STAGES; i++) begin
                stage_data[i] <= RESET_VALUE;
            end
            occupancy <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (stage_ready[i]) begin
                    // NOTE: non-blocking, so every slice samples its neighbour's pre-edge value and words advance one slice per edge.
                    stage_valid[i] <= src_valid[i];
                    // A bubble advances without disturbing the data register.
                    if (src_valid[i]) begin
                        stage_data[i] <= src_data[i];
                    end
                end
            end
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
        end
    end

endmodule

// File: tb/tb_register_pipeline.sv
// -----------------------------------------------------------------------------
// tb_register_pipeline
//   Directed, table-driven bench for register_pipeline. The main vector table
//   runs against a STAGES=2 instance. STAGES=1 and STAGES=4 instances share the
//   same inputs and are checked for reset clearing and for latency after reset.
// -----------------------------------------------------------------------------
module tb_register_pipeline;

    localparam logic [31:0] RV = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  occ2;
    logic        in_ready1, out_valid1;
    logic [31:0] out_data1;
    logic [0:0]  occ1;
    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [2:0]  occ4;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    register_pipeline #(.WIDTH(32), .STAGES(2), .RESET_VALUE(RV)) u_dut2 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occ2)
    );

    register_pipeline #(.WIDTH(32), .STAGES(1), .RESET_VALUE(RV)) u_dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    register_pipeline #(.WIDTH(32), .STAGES(4), .RESET_VALUE(RV)) u_dut4 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .occupancy(occ4)
    );

    // A vector gives the inputs for one cycle, the in_ready expected before the
    // edge, and the outputs expected after the edge. out_data is checked only when cd=1.
    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [2:0]  e_occ;
        logic        cd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic fl, logic iv, logic [31:0] id, logic ordy,
                                 logic e_ir, logic e_ov, logic [31:0] e_od,
                                 logic [2:0] e_occ, logic cd);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.cd = cd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Back-to-back stream 0x1..0x8 with out_ready held high, then drain.
        vecs.push_back(mkv(0, 1, 32'h1, 1, 1, 0, 0, 1, 0));
        for (int k = 2; k <= 8; k++) begin
            vecs.push_back(mkv(0, 1, 32'(k), 1, 1, 1, 32'(k - 1), 2, 1));
        end
        vecs.push_back(mkv(0, 0, 0, 1, 1, 1, 32'h8, 1, 1));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 0));
        // Stalled fill with A, B, C: C waits, then all three drain in order.
        vecs.push_back(mkv(0, 1, 32'hA, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 1, 32'hB, 0, 1, 1, 32'hA, 2, 1));
        vecs.push_back(mkv(0, 1, 32'hC, 0, 0, 1, 32'hA, 2, 1));
        vecs.push_back(mkv(0, 1, 32'hC, 0, 0, 1, 32'hA, 2, 1));
        vecs.push_back(mkv(0, 1, 32'hC, 1, 1, 1, 32'hB, 2, 1));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 1, 32'hC, 1, 1));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 0));
        // Bubble between 0x5 and 0x6 with out_ready toggling.
        vecs.push_back(mkv(0, 1, 32'h5, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 1, 32'h5, 1, 1));
        vecs.push_back(mkv(0, 1, 32'h6, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 0, 0, 0, 1, 1, 32'h6, 1, 1));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0, 0, 0));
        // Full pipe flushed while stalled: 0x77 is dropped.
        vecs.push_back(mkv(0, 1, 32'h11, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 1, 32'h22, 0, 1, 1, 32'h11, 2, 1));
        vecs.push_back(mkv(1, 1, 32'h77, 0, 0, 0, RV, 0, 1));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 0, RV, 0, 1));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 0, RV, 0, 1));
        // Full pipe flushed during a simultaneous push and pop.
        vecs.push_back(mkv(0, 1, 32'h33, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 1, 32'h44, 1, 1, 1, 32'h33, 2, 1));
        vecs.push_back(mkv(1, 1, 32'h77, 1, 1, 0, RV, 0, 1));
        vecs.push_back(mkv(0, 0, 0, 1, 1, 0, RV, 0, 1));

        // Reset held for two edges while upstream offers data.
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hFF; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset out_valid s2", 32'(out_valid2), 0);
        check("reset out_data s2", out_data2, RV);
        check("reset occupancy s2", 32'(occ2), 0);
        check("reset in_ready s2", 32'(in_ready2), 1);
        check("reset out_valid s1", 32'(out_valid1), 0);
        check("reset out_data s1", out_data1, RV);
        check("reset occupancy s1", 32'(occ1), 0);
        check("reset out_valid s4", 32'(out_valid4), 0);
        check("reset out_data s4", out_data4, RV);
        check("reset occupancy s4", 32'(occ4), 0);
        reset = 1'b1; in_valid = 1'b0; in_data = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].id;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(in_ready2), 32'(vecs[i].e_ir));
            @(posedge clock);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid2), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d occupancy", i), 32'(occ2), 32'(vecs[i].e_occ));
            if (vecs[i].cd) begin
                check($sformatf("vec%0d out_data", i), out_data2, vecs[i].e_od);
            end
        end

        // Load the pipes mid-stream, then assert reset together with flush and a push.
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1234;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0; flush = 1'b1; in_data = 32'h99;
        @(posedge clock);
        #1;
        check("midreset out_valid s2", 32'(out_valid2), 0);
        check("midreset out_data s2", out_data2, RV);
        check("midreset occupancy s2", 32'(occ2), 0);
        check("midreset in_ready s2", 32'(in_ready2), 1);
        check("midreset out_valid s1", 32'(out_valid1), 0);
        check("midreset in_ready s1", 32'(in_ready1), 1);
        check("midreset out_valid s4", 32'(out_valid4), 0);
        check("midreset occupancy s4", 32'(occ4), 0);

        // One word 0x9 after release must surface after exactly STAGES edges.
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h9;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) begin
                in_valid = 1'b0;
                in_data  = 0;
            end
            check($sformatf("latency s1 edge%0d", k), 32'(out_valid1), 32'(k == 1));
            check($sformatf("latency s2 edge%0d", k), 32'(out_valid2), 32'(k == 2));
            check($sformatf("latency s4 edge%0d", k), 32'(out_valid4), 32'(k == 4));
            if (k == 1) check("latency data s1", out_data1, 32'h9);
            if (k == 2) check("latency data s2", out_data2, 32'h9);
            if (k == 4) check("latency data s4", out_data4, 32'h9);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
